i2s_slave_tx_ram_reader: RTL
============================

Name: i2s_slave_tx_ram_reader

Overview:
Transmit-side counterpart of the I2S slave Rx RAM block. It reads 16-bit mono samples from a 2x1024x16 ping-pong RAM and serializes them onto the I2S data line. WS and SCK come from an external I2S master. A one-cycle pulse is issued each time a bank is fully drained, so the Wishbone/host side can refill that bank while the other bank plays.

Parameters:
RIGHT_MODE, 0, right-slot content: 0 = all zeros, 1 = duplicate of the left sample.
SAMPLE_W, 16, sample width in bits; fixed at 16 for the r1024x16 RAM.

Ports:
i2s_clk_i  in  1  I2S SCK from master; all logic on rising edge.
ram_logic_rst  in  1  asynchronous active-high reset.
i2s_ws_i  in  1  word select from master (0 = left, 1 = right).
i2s_sd_o  out  1  serial data, registered.
tx_enable_i  in  1  transmit enable level, already synchronized to i2s_clk_i.
bank_valid_i  in  2  per-bank "filled by host" flags, already synchronized.
ram_raddr_o  out  11  RAM read address; bit 10 selects the bank.
ram_rd_data_i  in  16  RAM read data; returns the address presented at the previous rising edge.
bank_empty_o  out  1  one-cycle pulse when a bank has been fully read.
bank_empty_bank_o  out  1  bank index just drained; valid with bank_empty_o.
underrun_o  out  1  sticky underrun flag.
underrun_clr_i  in  1  clears underrun_o.
tx_active_o  out  1  high while frames carry RAM data.

Behaviour:
- Reset (asynchronous, high): all outputs 0, read pointer rd_ptr = 0, ws_r = 1, shifter 0, bit counter 0, fetch_armed 0.
- WS edge detection uses ws_r (i2s_ws_i delayed one edge).
  - Left start (LS): ws_i = 0 and ws_r = 1.
  - Right start (RS): ws_i = 1 and ws_r = 0.
- Slot timing: at an LS or RS edge the shifter loads and i2s_sd_o = bit 15 on that same edge. The master therefore samples the MSB one SCK after the WS transition (standard I2S one-bit delay).
  - Each following edge shifts MSB-first.
  - After 16 bits, i2s_sd_o = 0 for the rest of the slot.
  - Bit counter is 5 bits and saturates at 31.
- Prefetch:
  - At RS with tx_enable_i = 1, set fetch_pend.
  - On the next edge (FETCH):
    - If bank_valid_i[rd_ptr[10]] = 1: prefetch_q <= ram_rd_data_i, rd_ptr <= rd_ptr + 1 (mod 2048), fetch_armed <= 1.
    - Otherwise: prefetch_q <= 0, rd_ptr holds, underrun_o <= 1, fetch_armed <= 1.
  - At RS with tx_enable_i = 0: fetch_armed <= 0.
- Left slot:
  - At LS, tx_active_o <= fetch_armed.
  - If armed, the shifter loads prefetch_q and hold_q <= prefetch_q. Otherwise the shifter loads 0.
- Right slot: at RS, the shifter loads hold_q if RIGHT_MODE = 1 and tx_active_o = 1; otherwise it loads 0.
- Enable/disable granularity: disabling mid-frame lets the current frame finish. The next frame outputs zeros and rd_ptr is frozen.
- Bank wrap: when an increment takes rd_ptr[9:0] from 0x3FF to 0x000, bank_empty_o = 1 for exactly one cycle (the edge after FETCH) and bank_empty_bank_o = old rd_ptr[10]. There is no pulse on underrun stalls.
- Underrun flag: underrun_o set has priority over underrun_clr_i in the same cycle.
- ram_raddr_o = rd_ptr, presented continuously and registered via rd_ptr.
- WS glitches: a slot shorter than 16 bits is truncated. A new LS/RS always reloads the shifter.
- Reset mid-frame: everything returns to reset values immediately. The first valid frame follows the next RS with enable.

Optional Feature:
Macro I2S_TX_BITREV_ADDR_EN.
- Defined: ram_raddr_o = {rd_ptr[10], bit-reversed rd_ptr[9:0]}. This matches the bit-reversed fill order used on the receive path.
- Undefined: ram_raddr_o = rd_ptr.
- Bank-wrap detection always uses the unreversed pointer.

Test Plan:
1. Reset, bank_valid = 11, tx_enable = 1, 32-SCK frames, RAM[n] = 0xA500+n -> first frame after RS outputs zeros; next left slot shifts 0xA500 MSB-first starting one SCK after WS fall; the following frame shifts 0xA501.
2. Stream 1024 frames -> bank_empty_o single pulse with bank_empty_bank_o = 0, ram_raddr_o = 0x400; after 2048 frames -> pulse with bank 1, ram_raddr_o = 0x000.
3. bank_valid = 01 across the bank-0 drain -> left slots 0, underrun_o = 1, ram_raddr_o stuck at 0x400, no pulse; then raise bit 1 -> RAM[0x400] transmitted; underrun_clr_i pulse -> underrun_o = 0.
4. RIGHT_MODE = 1, 64-SCK frames, sample 0x8001 -> right slot carries 0x8001; bits 16-31 of both slots are 0.
5. Drop tx_enable mid-left-slot -> current frame completes; the next frame is all zeros, tx_active_o = 0, pointer holds; re-enable -> resumes at the held address.
6. I2S_TX_BITREV_ADDR_EN defined -> rd_ptr = 1 gives ram_raddr_o = 0x200; rd_ptr = 0x401 gives 0x600. Assert reset mid-slot -> i2s_sd_o = 0 and ram_raddr_o = 0 immediately.

Source files
------------

// File: rtl/i2s_slave_tx_ram_reader.sv
// ============================================================================
//  Module      : i2s_slave_tx_ram_reader
//  Description : I2S slave transmitter. Reads 16-bit mono samples from a
//                2x1024x16 ping-pong RAM and shifts them out MSB-first, one
//                SCK after each WS transition. Pulses bank_empty_o when a
//                bank has been fully drained so the host can refill it.
//                Optional macro I2S_TX_BITREV_ADDR_EN bit-reverses the
//                in-bank part of the RAM read address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_slave_tx_ram_reader #(
   parameter int RIGHT_MODE = 0,   // 0: right slot zeros, 1: right = left
   parameter int SAMPLE_W   = 16   // fixed by the r1024x16 RAM
) (
   input  logic                i2s_clk_i,
   input  logic                ram_logic_rst,
   input  logic                i2s_ws_i,
   output logic                i2s_sd_o,
   input  logic                tx_enable_i,
   input  logic [1:0]          bank_valid_i,
   output logic [10:0]         ram_raddr_o,
   input  logic [SAMPLE_W-1:0] ram_rd_data_i,
   output logic                bank_empty_o,
   output logic                bank_empty_bank_o,
   output logic                underrun_o,
   input  logic                underrun_clr_i,
   output logic                tx_active_o
);

   localparam logic [4:0] c_SLOT_BITS = 5'(SAMPLE_W);
   localparam logic [4:0] c_CNT_MAX   = 5'd31;
   localparam logic [9:0] c_BANK_LAST = 10'h3FF;

   // Registered state
   logic                ws_q,           ws_d;
   logic                sd_q,           sd_d;
   logic [SAMPLE_W-1:0] shift_q,        shift_d;
   logic [4:0]          bit_cnt_q,      bit_cnt_d;
   logic                fetch_pend_q,   fetch_pend_d;
   logic                fetch_armed_q,  fetch_armed_d;
   logic [10:0]         rd_ptr_q,       rd_ptr_d;
   logic [SAMPLE_W-1:0] prefetch_q,     prefetch_d;
   logic [SAMPLE_W-1:0] hold_q,         hold_d;
   logic                tx_active_q,    tx_active_d;
   logic                underrun_q,     underrun_d;
   logic                bank_empty_q,   bank_empty_d;
   logic                empty_bank_q,   empty_bank_d;

   // Combinational helpers
   logic                w_ls;
   logic                w_rs;
   logic                w_underrun_set;
   logic [SAMPLE_W-1:0] w_load;

   assign w_ls = ~i2s_ws_i &  ws_q;
   assign w_rs =  i2s_ws_i & ~ws_q;

   // Next-state: WS tracking, sample prefetch, slot loading and bit shifting
   always_comb begin
      ws_d           = i2s_ws_i;
      sd_d           = 1'b0;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      fetch_pend_d   = fetch_pend_q;
      fetch_armed_d  = fetch_armed_q;
      rd_ptr_d       = rd_ptr_q;
      prefetch_d     = prefetch_q;
      hold_d         = hold_q;
      tx_active_d    = tx_active_q;
      underrun_d     = underrun_q;
      bank_empty_d   = 1'b0;
      empty_bank_d   = empty_bank_q;
      w_underrun_set = 1'b0;
      w_load         = '0;

      // The cycle after a right-slot start: RAM data for rd_ptr is on the bus.
      if (fetch_pend_q) begin
         fetch_pend_d  = 1'b0;
         fetch_armed_d = 1'b1;
         if (bank_valid_i[rd_ptr_q[10]]) begin
            prefetch_d = ram_rd_data_i;
            rd_ptr_d   = rd_ptr_q + 11'd1;
            if (rd_ptr_q[9:0] == c_BANK_LAST) begin
               bank_empty_d = 1'b1;
               empty_bank_d = rd_ptr_q[10];
            end
         end else begin
            // Host has not refilled this bank: play silence, hold the pointer.
            prefetch_d     = '0;
            w_underrun_set = 1'b1;
         end
      end

      // Enable is only honoured at frame granularity (right-slot start).
      if (w_rs) begin
         if (tx_enable_i) begin
            fetch_pend_d = 1'b1;
         end else begin
            fetch_pend_d  = 1'b0;
            fetch_armed_d = 1'b0;
         end
      end

      if (w_underrun_set) begin
         underrun_d = 1'b1;
      end else if (underrun_clr_i) begin
         underrun_d = 1'b0;
      end

      if (w_ls) begin
         tx_active_d = fetch_armed_q;
         if (fetch_armed_q) begin
            w_load = prefetch_q;
            hold_d = prefetch_q;
         end
      end else if (w_rs) begin
         if ((RIGHT_MODE != 0) && tx_active_q) begin
            w_load = hold_q;
         end
      end

      // Any slot start reloads the shifter, truncating a short slot.
      if (w_ls || w_rs) begin
         sd_d      = w_load[SAMPLE_W-1];
         shift_d   = {w_load[SAMPLE_W-2:0], 1'b0};
         bit_cnt_d = 5'd1;
      end else begin
         if (bit_cnt_q < c_SLOT_BITS) begin
            sd_d = shift_q[SAMPLE_W-1];
         end
         shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
         if (bit_cnt_q != c_CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
         end
      end
   end

   // State register, asynchronous reset to idle with WS assumed high
   always_ff @(posedge i2s_clk_i or posedge ram_logic_rst) begin
      if (ram_logic_rst) begin
         ws_q          <= 1'b1;
         sd_q          <= 1'b0;
         shift_q       <= '0;
         bit_cnt_q     <= 5'd0;
         fetch_pend_q  <= 1'b0;
         fetch_armed_q <= 1'b0;
         rd_ptr_q      <= 11'd0;
         prefetch_q    <= '0;
         hold_q        <= '0;
         tx_active_q   <= 1'b0;
         underrun_q    <= 1'b0;
         bank_empty_q  <= 1'b0;
         empty_bank_q  <= 1'b0;
      end else begin
         ws_q          <= ws_d;
         sd_q          <= sd_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         fetch_pend_q  <= fetch_pend_d;
         fetch_armed_q <= fetch_armed_d;
         rd_ptr_q      <= rd_ptr_d;
         prefetch_q    <= prefetch_d;
         hold_q        <= hold_d;
         tx_active_q   <= tx_active_d;
         underrun_q    <= underrun_d;
         bank_empty_q  <= bank_empty_d;
         empty_bank_q  <= empty_bank_d;
      end
   end

`ifdef I2S_TX_BITREV_ADDR_EN
   // In-bank address bit-reversed to match the receive-side fill order;
   // wrap detection above still works on the linear pointer.
   logic [9:0] w_rev_addr;
   for (genvar gi = 0; gi < 10; gi++) begin : g_bitrev
      assign w_rev_addr[gi] = rd_ptr_q[9-gi];
   end
   assign ram_raddr_o = {rd_ptr_q[10], w_rev_addr};
`else
   assign ram_raddr_o = rd_ptr_q;
`endif

   assign i2s_sd_o          = sd_q;
   assign bank_empty_o      = bank_empty_q;
   assign bank_empty_bank_o = empty_bank_q;
   assign underrun_o        = underrun_q;
   assign tx_active_o       = tx_active_q;

endmodule

`default_nettype wire
